// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: load-use stalls, branch flushes, imem wait states
//
// Purpose: drives the PC write enable and the IF/ID and ID/EX pipeline-register
// controls of a 5-stage MIPS datapath. A small registered FSM stretches
// load-use stalls over STALL_CYCLES and tracks instruction-memory wait states.
// Outputs are combinational from the registered state and the current inputs.
//
// Optional build macro: HZD_PERF_COUNTERS_EN adds stallCount/flushCount/waitCount.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   idRs/idRt    in   [4:0] source registers of the instruction in ID
//   idUsesRt     in   ID instruction reads rt
//   exRt         in   [4:0] destination rt of the instruction in EX
//   exMemRead    in   EX instruction is a load
//   branchTaken  in   branch/jump resolved taken in EX
//   imemReady    in   instruction memory data valid this cycle
//   hzdWrite     out  PC write enable
//   ifidWrite    out  IF/ID write enable
//   ifidFlush    out  IF/ID loads a NOP
//   idexBubble   out  ID/EX control fields forced to zero
//   fetchTimeout out  sticky instruction-memory timeout flag (registered)
//   state        out  [1:0] current FSM state
//   stallCount, flushCount, waitCount  out [31:0] (HZD_PERF_COUNTERS_EN only)
module hazard_unit #(
  parameter int STALL_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRt,
  input  logic [4:0]  exRt,
  input  logic        exMemRead,
  input  logic        branchTaken,
  input  logic        imemReady,
  output logic        hzdWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        fetchTimeout,
  output logic [1:0]  state
`ifdef HZD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount,
  output logic [31:0] waitCount
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2,
    UNUSED     = 2'd3
  } state_t;

  localparam logic [3:0]  STALL_INIT = 4'(STALL_CYCLES - 1);
  localparam logic [15:0] WAIT_MAX   = 16'(TIMEOUT_CYCLES);

  state_t      cur;
  logic [3:0]  stall_cnt;
  logic [15:0] wait_cnt;

  logic load_use;
  logic do_flush;
  logic do_stall;
  logic do_wait;

  // Register $0 is hardwired to zero, so a load targeting it is harmless.
  assign load_use = exMemRead && (exRt != 5'd0) &&
                    ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

  // One-hot decision of which action owns this cycle, in priority order.
  // While reset is held low none apply, which yields the RUN outputs.
  always_comb begin
    do_flush = 1'b0;
    do_stall = 1'b0;
    do_wait  = 1'b0;
    if (!reset) begin
      do_flush = 1'b0;
    end else if (branchTaken) begin
      do_flush = 1'b1;
    end else if (cur == UNUSED) begin
      // Illegal encoding: behave as RUN for one cycle, then recover.
      do_flush = 1'b0;
    end else if ((cur == LOAD_STALL) || load_use) begin
      do_stall = 1'b1;
    end else if (!imemReady) begin
      do_wait = 1'b1;
    end
  end

  assign hzdWrite   = !(do_stall || do_wait);
  assign ifidWrite  = !do_stall;
  assign ifidFlush  = do_flush || do_wait;
  assign idexBubble = do_flush || do_stall;
  assign state      = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur          <= RUN;
      stall_cnt    <= 4'd0;
      wait_cnt     <= 16'd0;
      fetchTimeout <= 1'b0;
    end else if (do_flush || (cur == UNUSED)) begin
      cur       <= RUN;
      stall_cnt <= 4'd0;
      wait_cnt  <= 16'd0;
    end else if (do_stall) begin
      wait_cnt <= 16'd0;
      if (cur == LOAD_STALL) begin
        // The entry cycle already froze the PC once, so leave on count 1.
        if (stall_cnt <= 4'd1) begin
          cur       <= RUN;
          stall_cnt <= 4'd0;
        end else begin
          stall_cnt <= stall_cnt - 4'd1;
        end
      end else if (STALL_CYCLES > 1) begin
        cur       <= LOAD_STALL;
        stall_cnt <= STALL_INIT;
      end else begin
        cur       <= RUN;
        stall_cnt <= 4'd0;
      end
    end else if (do_wait) begin
      cur <= IMEM_WAIT;
      if (cur == IMEM_WAIT) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 16'd1;
        end
        // Flag is raised on the edge where the count arrives at the limit.
        if (wait_cnt >= (WAIT_MAX - 16'd1)) begin
          fetchTimeout <= 1'b1;
        end
      end else begin
        wait_cnt <= 16'd1;
      end
    end else begin
      cur       <= RUN;
      stall_cnt <= 4'd0;
      wait_cnt  <= 16'd0;
    end
  end

`ifdef HZD_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= 32'd0;
      flushCount <= 32'd0;
      waitCount  <= 32'd0;
    end else begin
      if (do_stall) begin
        stallCount <= stallCount + 32'd1;
      end
      if (branchTaken) begin
        flushCount <= flushCount + 32'd1;
      end
      if (do_wait && (cur == IMEM_WAIT)) begin
        waitCount <= waitCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard testbench for hazard_unit (three parameter sets)
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUsesRt;
  logic [4:0] exRt;
  logic       exMemRead;
  logic       branchTaken;
  logic       imemReady;

  logic       hzd_a, ifw_a, fl_a, bb_a, to_a;
  logic       hzd_b, ifw_b, fl_b, bb_b, to_b;
  logic       hzd_c, ifw_c, fl_c, bb_c, to_c;
  logic [1:0] st_a, st_b, st_c;
`ifdef HZD_PERF_COUNTERS_EN
  logic [31:0] sc_a, fc_a, wc_a, sc_b, fc_b, wc_b, sc_c, fc_c, wc_c;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // a: STALL=1 TIMEOUT=64, b: STALL=3 TIMEOUT=64, c: STALL=1 TIMEOUT=4
  hazard_unit #(.STALL_CYCLES(1), .TIMEOUT_CYCLES(64)) dut_a (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRt(exRt), .exMemRead(exMemRead), .branchTaken(branchTaken), .imemReady(imemReady),
    .hzdWrite(hzd_a), .ifidWrite(ifw_a), .ifidFlush(fl_a), .idexBubble(bb_a),
    .fetchTimeout(to_a), .state(st_a)
`ifdef HZD_PERF_COUNTERS_EN
    , .stallCount(sc_a), .flushCount(fc_a), .waitCount(wc_a)
`endif
  );

  hazard_unit #(.STALL_CYCLES(3), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRt(exRt), .exMemRead(exMemRead), .branchTaken(branchTaken), .imemReady(imemReady),
    .hzdWrite(hzd_b), .ifidWrite(ifw_b), .ifidFlush(fl_b), .idexBubble(bb_b),
    .fetchTimeout(to_b), .state(st_b)
`ifdef HZD_PERF_COUNTERS_EN
    , .stallCount(sc_b), .flushCount(fc_b), .waitCount(wc_b)
`endif
  );

  hazard_unit #(.STALL_CYCLES(1), .TIMEOUT_CYCLES(4)) dut_c (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRt(exRt), .exMemRead(exMemRead), .branchTaken(branchTaken), .imemReady(imemReady),
    .hzdWrite(hzd_c), .ifidWrite(ifw_c), .ifidFlush(fl_c), .idexBubble(bb_c),
    .fetchTimeout(to_c), .state(st_c)
`ifdef HZD_PERF_COUNTERS_EN
    , .stallCount(sc_c), .flushCount(fc_c), .waitCount(wc_c)
`endif
  );

  // {hzdWrite, ifidWrite, ifidFlush, idexBubble}
  localparam logic [3:0] C_RUN = 4'b1100;
  localparam logic [3:0] C_LU  = 4'b0001;
  localparam logic [3:0] C_BR  = 4'b1111;
  localparam logic [3:0] C_WT  = 4'b0110;

  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] o(input logic [3:0] ctl, input logic to, input logic [1:0] st);
    return {ctl, to, st};
  endfunction

  function automatic logic [6:0] observed(input int sel);
    case (sel)
      0:       return {hzd_a, ifw_a, fl_a, bb_a, to_a, st_a};
      1:       return {hzd_b, ifw_b, fl_b, bb_b, to_b, st_b};
      default: return {hzd_c, ifw_c, fl_c, bb_c, to_c, st_c};
    endcase
  endfunction

  // Compare everything queued for this cycle, half a period after inputs change.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, 32'(observed(e.sel)), 32'(e.exp));
    end
  end

  task automatic exp3(input string tag, input logic [6:0] ea, input logic [6:0] eb, input logic [6:0] ec);
    sb.push_back('{tag: {tag, "_a"}, sel: 0, exp: ea});
    sb.push_back('{tag: {tag, "_b"}, sel: 1, exp: eb});
    sb.push_back('{tag: {tag, "_c"}, sel: 2, exp: ec});
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic [4:0] ert, input logic mr, input logic br, input logic rdy);
    idRs        = rs;
    idRt        = rt;
    idUsesRt    = uses;
    exRt        = ert;
    exMemRead   = mr;
    branchTaken = br;
    imemReady   = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a load-use pattern present: outputs must still be RUN.
    reset = 1'b0;
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    exp3("rst_hold", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();
    exp3("rst_hold2", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();
    reset = 1'b1;
    idle();
    exp3("idle", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // Load-use on rs
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    exp3("lu_rs0", o(C_LU, 0, 0), o(C_LU, 0, 0), o(C_LU, 0, 0));
    cyc();
    idle();
    exp3("lu_rs1", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 0, 0));
    cyc();
    exp3("lu_rs2", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 0, 0));
    cyc();
    exp3("lu_rs3", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // Load-use on rt
    drive(5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    exp3("lu_rt0", o(C_LU, 0, 0), o(C_LU, 0, 0), o(C_LU, 0, 0));
    cyc();
    idle();
    exp3("lu_rt1", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 0, 0));
    cyc();
    exp3("lu_rt2", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 0, 0));
    cyc();
    exp3("lu_rt3", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // rt match without idUsesRt, and a load into $0: no stall
    drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    exp3("no_uses_rt", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    exp3("reg_zero", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // Branch aborts a pending stall (b is in LOAD_STALL with count 2)
    drive(5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    exp3("bos_lu", o(C_LU, 0, 0), o(C_LU, 0, 0), o(C_LU, 0, 0));
    cyc();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    exp3("bos_br", o(C_BR, 0, 0), o(C_BR, 0, 1), o(C_BR, 0, 0));
    cyc();
    idle();
    exp3("bos_after", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // Branch outranks a simultaneous load-use
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    exp3("br_over_lu", o(C_BR, 0, 0), o(C_BR, 0, 0), o(C_BR, 0, 0));
    cyc();
    idle();
    exp3("br_over_lu_after", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

    // Imem wait for 6 cycles; c (TIMEOUT=4) flags from the 4th edge on
    for (int i = 0; i < 6; i++) begin
      logic [1:0] st;
      logic       toc;
      st  = (i == 0) ? 2'd0 : 2'd2;
      toc = (i >= 4);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      exp3($sformatf("wait%0d", i), o(C_WT, 0, st), o(C_WT, 0, st), o(C_WT, toc, st));
      cyc();
    end
    idle();
    exp3("wait_release", o(C_RUN, 0, 2), o(C_RUN, 0, 2), o(C_RUN, 1, 2));
    cyc();
    exp3("wait_after", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 1, 0));
    cyc();

    // Load-use arriving during IMEM_WAIT
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp3("wlu_enter", o(C_WT, 0, 0), o(C_WT, 0, 0), o(C_WT, 1, 0));
    cyc();
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    exp3("wlu_lu", o(C_LU, 0, 2), o(C_LU, 0, 2), o(C_LU, 1, 2));
    cyc();
    idle();
    exp3("wlu_1", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 1, 0));
    cyc();
    exp3("wlu_2", o(C_RUN, 0, 0), o(C_LU, 0, 1), o(C_RUN, 1, 0));
    cyc();
    exp3("wlu_3", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 1, 0));
    cyc();

    // Branch during IMEM_WAIT
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp3("wbr_enter", o(C_WT, 0, 0), o(C_WT, 0, 0), o(C_WT, 1, 0));
    cyc();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp3("wbr_br", o(C_BR, 0, 2), o(C_BR, 0, 2), o(C_BR, 1, 2));
    cyc();
    idle();
    exp3("wbr_after", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 1, 0));
    cyc();

    // Asynchronous reset in the middle of IMEM_WAIT (checked before any edge)
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp3("arst_enter", o(C_WT, 0, 0), o(C_WT, 0, 0), o(C_WT, 1, 0));
    cyc();
    exp3("arst_wait", o(C_WT, 0, 2), o(C_WT, 0, 2), o(C_WT, 1, 2));
    cyc();
    reset = 1'b0;
    exp3("arst_now", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();
    reset = 1'b1;
    idle();
    exp3("arst_after", o(C_RUN, 0, 0), o(C_RUN, 0, 0), o(C_RUN, 0, 0));
    cyc();

`ifdef HZD_PERF_COUNTERS_EN
    // 2 load-use stalls, 3 branches, 4 IMEM_WAIT cycles on dut_a
    for (int i = 0; i < 2; i++) begin
      drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
      cyc();
      idle();
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    idle();
    cyc();
    #6;
    check_eq("perf_stall", sc_a, 32'd2);
    check_eq("perf_flush", fc_a, 32'd3);
    check_eq("perf_wait", wc_a, 32'd4);
`endif

    #6;
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
